// File: rtl/mips_pkg.sv
// Shared fetch-stage types and constants.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction, PC+4 and valid flag.
// Clear wins over load and inserts a bubble.
module if_id_reg #(
    parameter int                 DATA_W    = 32,
    parameter logic [DATA_W-1:0]  NOP_INSTR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] instr_i,
    input  logic [DATA_W-1:0] pc_plus4_i,
    output logic [DATA_W-1:0] instr_o,
    output logic [DATA_W-1:0] pc_plus4_o,
    output logic              valid_o
);

    logic [DATA_W-1:0] instr_q;
    logic [DATA_W-1:0] pc_plus4_q;
    logic              valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else if (clear_i) begin
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else if (load_i) begin
            instr_q    <= instr_i;
            pc_plus4_q <= pc_plus4_i;
            valid_q    <= 1'b1;
        end
    end

    assign instr_o    = instr_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives the instruction memory request,
// holds the PC on stalls, and feeds the IF/ID register with skid buffering.
module fetch_ctrl
    import mips_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NOP_INSTR_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pc,
    input  logic              stall_d,
    input  logic              flush_d,
    input  logic              imem_ready,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              imem_req,
    output logic [DATA_W-1:0] imem_addr,
    output logic              stall_f,
    output logic [DATA_W-1:0] instr_d,
    output logic [DATA_W-1:0] pc_plus4_d,
    output logic              valid_d
);

    fetch_state_t      state_q, state_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic [DATA_W-1:0] addr_hold_q, addr_hold_d;

    logic              ifid_load;
    logic              ifid_clear;
    logic [DATA_W-1:0] ifid_instr;
    logic [DATA_W-1:0] pc_plus4;

    // PC is held whenever a word waits in the skid buffer, so pc+4 is always correct here.
    assign pc_plus4 = pc + DATA_W'(4);

    always_comb begin
        state_d     = state_q;
        skid_d      = skid_q;
        addr_hold_d = addr_hold_q;
        stall_f     = 1'b1;
        ifid_load   = 1'b0;
        ifid_clear  = 1'b0;
        ifid_instr  = imem_rdata;

        case (state_q)
            IDLE: begin
                ifid_clear = 1'b1;
                state_d    = FETCH;
            end
            FETCH: begin
                if (flush_d) begin
                    stall_f    = 1'b0;
                    ifid_clear = 1'b1;
                    // A request still in flight must be drained before the redirect target is fetched.
                    if (!imem_ready) begin
                        addr_hold_d = pc;
                        state_d     = DROP;
                    end
                end else if (imem_ready) begin
                    if (stall_d) begin
                        skid_d  = imem_rdata;
                        state_d = HOLD;
                    end else begin
                        stall_f   = 1'b0;
                        ifid_load = 1'b1;
                    end
                end else if (!stall_d) begin
                    ifid_clear = 1'b1;
                end
            end
            HOLD: begin
                if (flush_d) begin
                    stall_f    = 1'b0;
                    ifid_clear = 1'b1;
                    state_d    = FETCH;
                end else if (!stall_d) begin
                    stall_f    = 1'b0;
                    ifid_load  = 1'b1;
                    ifid_instr = skid_q;
                    state_d    = FETCH;
                end
            end
            DROP: begin
                ifid_clear = 1'b1;
                if (imem_ready) begin
                    state_d = FETCH;
                end
            end
            default: begin
                ifid_clear = 1'b1;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            skid_q      <= '0;
            addr_hold_q <= '0;
        end else begin
            state_q     <= state_d;
            skid_q      <= skid_d;
            addr_hold_q <= addr_hold_d;
        end
    end

    assign imem_req  = (state_q == FETCH) || (state_q == DROP);
    assign imem_addr = (state_q == DROP) ? addr_hold_q : pc;

    if_id_reg #(
        .DATA_W    (DATA_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .load_i     (ifid_load),
        .clear_i    (ifid_clear),
        .instr_i    (ifid_instr),
        .pc_plus4_i (pc_plus4),
        .instr_o    (instr_d),
        .pc_plus4_o (pc_plus4_d),
        .valid_o    (valid_d)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl; a non-zero NOP word makes bubbles visible.
module tb_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        stall_d;
    logic        flush_d;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        stall_f;
    logic [31:0] instr_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;

    int checks;
    int failures;

    fetch_ctrl #(
        .DATA_W    (32),
        .NOP_INSTR (NOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .stall_d    (stall_d),
        .flush_d    (flush_d),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .stall_f    (stall_f),
        .instr_d    (instr_d),
        .pc_plus4_d (pc_plus4_d),
        .valid_d    (valid_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [31:0] pcV, input logic readyV,
                                 input logic [31:0] rdataV, input logic stallV,
                                 input logic flushV);
        pc         = pcV;
        imem_ready = readyV;
        imem_rdata = rdataV;
        stall_d    = stallV;
        flush_d    = flushV;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        assert (actual === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIfId(input string tag, input logic [31:0] instrE,
                             input logic [31:0] pc4E, input logic validE);
        checkOutput({tag, "_instr"}, instr_d, instrE);
        checkOutput({tag, "_pc4"}, pc_plus4_d, pc4E);
        checkOutput({tag, "_valid"}, 32'(valid_d), 32'(validE));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        applyStimulus(32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;

        checkOutput("rst_req", 32'(imem_req), 32'd0);
        checkOutput("rst_stallf", 32'(stall_f), 32'd1);
        checkIfId("rst", NOP, 32'h0, 1'b0);

        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checkOutput("idle_req", 32'(imem_req), 32'd0);
        checkOutput("idle_stallf", 32'(stall_f), 32'd1);
        tick();

        // Zero-wait stream at pc 0, 4, 8
        for (int i = 0; i < 3; i++) begin
            applyStimulus(32'(i * 4), 1'b1, 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
            checkOutput("stream_req", 32'(imem_req), 32'd1);
            checkOutput("stream_addr", imem_addr, 32'(i * 4));
            checkOutput("stream_stallf", 32'(stall_f), 32'd0);
            tick();
            checkIfId("stream", 32'hA000_0000 + 32'(i), 32'(i * 4 + 4), 1'b1);
        end

        // Memory not ready while decode stalls: IF/ID holds
        applyStimulus(32'h0C, 1'b0, 32'hBAD0_0000, 1'b1, 1'b0);
        checkOutput("waitstall_stallf", 32'(stall_f), 32'd1);
        tick();
        checkIfId("waitstall", 32'hA000_0002, 32'd12, 1'b1);

        // Three wait cycles at pc 0x40 give three bubbles
        for (int i = 0; i < 3; i++) begin
            applyStimulus(32'h40, 1'b0, 32'hBAD0_0001, 1'b0, 1'b0);
            checkOutput("wait_stallf", 32'(stall_f), 32'd1);
            checkOutput("wait_addr", imem_addr, 32'h40);
            tick();
            checkIfId("wait_bubble", NOP, 32'h0, 1'b0);
        end
        applyStimulus(32'h40, 1'b1, 32'hB000_0040, 1'b0, 1'b0);
        checkOutput("wait_done_stallf", 32'(stall_f), 32'd0);
        tick();
        checkIfId("wait_done", 32'hB000_0040, 32'h44, 1'b1);

        // Response arrives during decode stall: skid, then release
        applyStimulus(32'h44, 1'b1, 32'hC000_0044, 1'b1, 1'b0);
        checkOutput("skid_stallf", 32'(stall_f), 32'd1);
        tick();
        checkIfId("skid_hold1", 32'hB000_0040, 32'h44, 1'b1);
        applyStimulus(32'h44, 1'b0, 32'hBAD0_0002, 1'b1, 1'b0);
        checkOutput("hold_req", 32'(imem_req), 32'd0);
        checkOutput("hold_stallf", 32'(stall_f), 32'd1);
        tick();
        checkIfId("skid_hold2", 32'hB000_0040, 32'h44, 1'b1);
        applyStimulus(32'h44, 1'b0, 32'hBAD0_0003, 1'b0, 1'b0);
        checkOutput("release_stallf", 32'(stall_f), 32'd0);
        tick();
        checkIfId("release", 32'hC000_0044, 32'h48, 1'b1);

        // Flush with a request pending at 0x100: drain it in DROP
        applyStimulus(32'h100, 1'b0, 32'hBAD0_0004, 1'b0, 1'b1);
        checkOutput("flushpend_addr", imem_addr, 32'h100);
        checkOutput("flushpend_stallf", 32'(stall_f), 32'd0);
        tick();
        checkIfId("flushpend", NOP, 32'h0, 1'b0);
        applyStimulus(32'h200, 1'b0, 32'hBAD0_0005, 1'b0, 1'b0);
        checkOutput("drop_req", 32'(imem_req), 32'd1);
        checkOutput("drop_addr", imem_addr, 32'h100);
        checkOutput("drop_stallf", 32'(stall_f), 32'd1);
        tick();
        checkIfId("drop_wait", NOP, 32'h0, 1'b0);
        applyStimulus(32'h200, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        checkOutput("drop_done_addr", imem_addr, 32'h100);
        checkOutput("drop_done_stallf", 32'(stall_f), 32'd1);
        tick();
        checkIfId("drop_late", NOP, 32'h0, 1'b0);
        applyStimulus(32'h200, 1'b1, 32'hD000_0200, 1'b0, 1'b0);
        checkOutput("redirect_addr", imem_addr, 32'h200);
        tick();
        checkIfId("redirect", 32'hD000_0200, 32'h204, 1'b1);

        // Flush while the response is ready: discarded, stay fetching
        applyStimulus(32'h204, 1'b1, 32'hBAD0_0006, 1'b0, 1'b1);
        checkOutput("flushrdy_stallf", 32'(stall_f), 32'd0);
        tick();
        checkIfId("flushrdy", NOP, 32'h0, 1'b0);
        applyStimulus(32'hFFFF_FFFC, 1'b1, 32'hE000_FFFC, 1'b0, 1'b0);
        checkOutput("flushrdy_req", 32'(imem_req), 32'd1);
        tick();
        checkIfId("wrap", 32'hE000_FFFC, 32'h0000_0000, 1'b1);

        // Flush beats stall in HOLD
        applyStimulus(32'h10, 1'b1, 32'hF000_0010, 1'b1, 1'b0);
        tick();
        checkIfId("hold_entry", 32'hE000_FFFC, 32'h0, 1'b1);
        applyStimulus(32'h10, 1'b0, 32'hBAD0_0007, 1'b1, 1'b1);
        checkOutput("holdflush_stallf", 32'(stall_f), 32'd0);
        tick();
        checkIfId("holdflush", NOP, 32'h0, 1'b0);
        applyStimulus(32'h300, 1'b0, 32'hBAD0_0008, 1'b0, 1'b0);
        checkOutput("holdflush_req", 32'(imem_req), 32'd1);

        // Reset pulse in the middle of DROP
        applyStimulus(32'h500, 1'b0, 32'hBAD0_0009, 1'b0, 1'b1);
        tick();
        applyStimulus(32'h600, 1'b0, 32'hBAD0_000A, 1'b0, 1'b0);
        checkOutput("middrop_addr", imem_addr, 32'h500);
        rst = 1'b1;
        #1;
        checkOutput("rstdrop_req", 32'(imem_req), 32'd0);
        checkOutput("rstdrop_stallf", 32'(stall_f), 32'd1);
        checkIfId("rstdrop", NOP, 32'h0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checkOutput("postrst_idle_req", 32'(imem_req), 32'd0);
        tick();
        checkOutput("postrst_fetch_req", 32'(imem_req), 32'd1);
        checkOutput("postrst_fetch_addr", imem_addr, 32'h600);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter NOP_INSTR, default 32'h0000_0000, instruction word loaded into IF/ID on bubble/flush/reset.
REQ-002 Parameter DATA_W, default 32, width of pc, instruction and address buses.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 pc  input  32  current PC from the PC register.
REQ-006 stall_d  input  1  decode stage cannot accept a new instruction.
REQ-007 flush_d  input  1  branch/jump redirect; squash fetched instruction.
REQ-008 imem_ready  input  1  instruction memory completes request this cycle.
REQ-009 imem_rdata  input  32  instruction word, valid when imem_ready=1.
REQ-010 imem_req  output  1  instruction fetch request.
REQ-011 imem_addr  output  32  fetch address, stable while imem_req=1 until imem_ready=1.
REQ-012 stall_f  output  1  combinational hold to the PC register (1 = hold PC).
REQ-013 instr_d  output  32  IF/ID instruction.
REQ-014 pc_plus4_d  output  32  IF/ID PC+4.
REQ-015 valid_d  output  1  IF/ID entry holds a real instruction.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, HOLD, DROP; IDLE exits to FETCH after one cycle unconditionally.
REQ-017 IDLE: imem_req=0, stall_f=1, IF/ID loads bubble (instr_d=NOP_INSTR, pc_plus4_d=0, valid_d=0).
REQ-018 FETCH: imem_req=1, imem_addr=pc (combinational).
REQ-019 FETCH, imem_ready=1, stall_d=0, flush_d=0: next edge instr_d<=imem_rdata, pc_plus4_d<=pc+4, valid_d<=1; stall_f=0; stay FETCH (zero-wait memory gives one instruction per cycle).
REQ-020 FETCH, imem_ready=1, stall_d=1, flush_d=0: imem_rdata captured into skid buffer, IF/ID holds, stall_f=1, go HOLD.
REQ-021 FETCH, imem_ready=0, flush_d=0: stall_f=1; IF/ID holds if stall_d=1, else loads bubble; stay FETCH.
REQ-022 FETCH, flush_d=1, imem_ready=1: response discarded, stall_f=0, IF/ID loads bubble, stay FETCH.
REQ-023 FETCH, flush_d=1, imem_ready=0: pc latched into addr_hold, stall_f=0, IF/ID loads bubble, go DROP.
REQ-024 DROP: imem_req=1, imem_addr=addr_hold, stall_f=1, IF/ID loads bubble; on imem_ready=1 response discarded, go FETCH.
REQ-025 HOLD: imem_req=0, stall_f=1 while stall_d=1 and flush_d=0, IF/ID holds.
REQ-026 HOLD, stall_d=0, flush_d=0: IF/ID loads skid buffer, pc+4, valid_d=1; stall_f=0; go FETCH.
REQ-027 HOLD, flush_d=1: skid buffer discarded, IF/ID loads bubble, stall_f=0, go FETCH.
REQ-028 flush_d SHALL take priority over stall_d in every state; flush_d in IDLE or DROP has no additional effect.
REQ-029 pc+4 SHALL wrap modulo 2^32 (pc=32'hFFFF_FFFC gives 32'h0000_0000).
REQ-030 stall_f=0 only in the cases of REQ-019, 022, 023, 026, 027; otherwise 1.

Reset
REQ-031 rst=1 SHALL immediately force state IDLE, instr_d=NOP_INSTR, pc_plus4_d=0, valid_d=0, skid buffer and addr_hold=0, imem_req=0, stall_f=1.
REQ-032 Reset during FETCH, HOLD or DROP SHALL abandon any outstanding request; the instruction memory SHALL tolerate abandoned requests.

Structure
REQ-033 fetch_state_t enum and NOP_INSTR default constant SHALL live in shared package mips_pkg.
REQ-034 IF/ID storage SHALL be a sub-module if_id_reg (instr, pc_plus4, valid; load-enable and clear inputs, async active-high reset).

Verification
REQ-035 Zero-wait memory, pc=0,4,8, stall_d=0 -> valid_d=1 each cycle, pc_plus4_d=4,8,12, stall_f=0 throughout.
REQ-036 imem_ready low 3 cycles at pc=32'h40 -> stall_f=1 for 3 cycles, 3 bubbles, then instr_d=rdata, pc_plus4_d=32'h44.
REQ-037 Response arrives with stall_d=1 for 2 cycles -> HOLD, IF/ID unchanged, imem_req=0; on release instr_d=buffered word, stall_f=0.
REQ-038 flush_d with request pending at pc=32'h100 -> stall_f=0 one cycle, DROP keeps imem_addr=32'h100 until ready, late word never reaches instr_d.
REQ-039 pc=32'hFFFF_FFFC fetched -> pc_plus4_d=32'h0000_0000; flush_d and stall_d together in HOLD -> bubble, valid_d=0.
REQ-040 rst pulsed mid-DROP -> imem_req=0 and valid_d=0 same cycle, IDLE one cycle after release, then FETCH.
